// File: rtl/adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : adder_pkg                                                      |
// | Brief    : Shared types and constants for the adder result datapath.      |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
package adder_pkg;

    localparam int ADD_RES_W   = 5;
    localparam int ADD_RES_MAX = 30;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_t;

    // Adder result as an unsigned beat value: carry-out is the MSB.
    function automatic logic [ADD_RES_W-1:0] beat_value(input logic cout,
                                                        input logic [3:0] sum);
        return {cout, sum};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_accum_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sat_accum_reg                                                  |
// | Brief    : Saturating accumulate register with clear and sticky overflow.|
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module sat_accum_reg
    import adder_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clear,
    input  logic                 i_add_en,
    input  logic [ADD_RES_W-1:0] i_value,
    output logic [ACC_W-1:0]     o_acc_next,
    output logic                 o_ovf_next
);

    localparam logic [ACC_W-1:0] c_acc_max = '1;

    logic [ACC_W-1:0] r_acc_q;
    logic [ACC_W-1:0] w_acc_d;
    logic             r_ovf_q;
    logic             w_ovf_d;
    logic [ACC_W:0]   w_sum;
    logic             w_sat;

    // One extra bit of headroom: acc <= max and value <= 31 can never wrap it.
    always_comb begin
        w_sum = {1'b0, r_acc_q} + {{(ACC_W + 1 - ADD_RES_W){1'b0}}, i_value};
        w_sat = w_sum[ACC_W];
    end

    always_comb begin
        o_acc_next = r_acc_q;
        o_ovf_next = r_ovf_q;
        if (i_add_en) begin
            o_acc_next = w_sat ? c_acc_max : w_sum[ACC_W-1:0];
            o_ovf_next = r_ovf_q | w_sat;
        end
    end

    always_comb begin
        w_acc_d = o_acc_next;
        w_ovf_d = o_ovf_next;
        if (i_clear) begin
            w_acc_d = '0;
            w_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_q <= '0;
            r_ovf_q <= 1'b0;
        end else begin
            r_acc_q <= w_acc_d;
            r_ovf_q <= w_ovf_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_sum_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : adder_sum_accumulator                                          |
// | Brief    : Frames adder results into saturating totals on valid/ready.   |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module adder_sum_accumulator
    import adder_pkg::*;
#(
    parameter int ACC_W     = 12,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_sum,
    input  logic             in_cout,
    input  logic             flush,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(FRAME_LEN - 1);

    acc_state_t       r_state_q;
    acc_state_t       w_state_d;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic [CNT_W-1:0] w_cnt_post;
    logic [ACC_W-1:0] r_total_q;
    logic [ACC_W-1:0] w_total_d;
    logic [CNT_W-1:0] r_count_q;
    logic [CNT_W-1:0] w_count_d;
    logic             r_ovf_out_q;
    logic             w_ovf_out_d;

    logic             w_take;
    logic             w_last;
    logic             w_close;
    logic             w_release;
    logic             w_acc_clear;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_ovf_next;

    // clear dominates everything: a coincident beat is dropped, not counted.
    always_comb begin
        w_take      = in_valid & in_ready & ~clear;
        w_cnt_post  = r_cnt_q + CNT_W'(w_take);
        w_last      = w_take & (r_cnt_q == c_last_cnt);
        w_close     = (r_state_q == ACCUM) & ~clear &
                      (w_last | (flush & (w_cnt_post != '0)));
        w_release   = (r_state_q == DONE) & out_ready & ~clear;
        w_acc_clear = clear | w_release;
    end

    sat_accum_reg #(
        .ACC_W (ACC_W)
    ) u_sat_accum_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_acc_clear),
        .i_add_en   (w_take),
        .i_value    (beat_value(in_cout, in_sum)),
        .o_acc_next (w_acc_next),
        .o_ovf_next (w_ovf_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= ACCUM;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        if (clear) begin
            w_state_d = ACCUM;
        end else begin
            case (r_state_q)
                ACCUM:   if (w_close)   w_state_d = DONE;
                DONE:    if (out_ready) w_state_d = ACCUM;
                default: w_state_d = ACCUM;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state_q)
            ACCUM:   in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (w_acc_clear) begin
            w_cnt_d = '0;
        end else if (w_take) begin
            w_cnt_d = w_cnt_post;
        end
    end

    // Result registers capture the post-update frame state and hold in DONE.
    always_comb begin
        w_total_d   = r_total_q;
        w_count_d   = r_count_q;
        w_ovf_out_d = r_ovf_out_q;
        if (clear) begin
            w_total_d   = '0;
            w_count_d   = '0;
            w_ovf_out_d = 1'b0;
        end else if (w_close) begin
            w_total_d   = w_acc_next;
            w_count_d   = w_cnt_post;
            w_ovf_out_d = w_ovf_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_q     <= '0;
            r_total_q   <= '0;
            r_count_q   <= '0;
            r_ovf_out_q <= 1'b0;
        end else begin
            r_cnt_q     <= w_cnt_d;
            r_total_q   <= w_total_d;
            r_count_q   <= w_count_d;
            r_ovf_out_q <= w_ovf_out_d;
        end
    end

    assign out_total    = r_total_q;
    assign out_count    = r_count_q;
    assign out_overflow = r_ovf_out_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_sum_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_adder_sum_accumulator                                       |
// | Brief    : Self-checking bench: directed table, random stimulus, model.  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_adder_sum_accumulator;

    localparam int FL    = 8;
    localparam int MAX_A = 4095;
    localparam int MAX_B = 63;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_sum;
    logic        in_cout;
    logic        flush;
    logic        clear;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_overflow;
    logic [11:0] a_out_total;
    logic [3:0]  a_out_count;
    logic        b_in_ready, b_out_valid, b_out_overflow;
    logic [5:0]  b_out_total;
    logic [3:0]  b_out_count;

    always #5 clk = ~clk;

    adder_sum_accumulator dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .flush(flush), .clear(clear),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_total(a_out_total),
        .out_count(a_out_count), .out_overflow(a_out_overflow)
    );

    adder_sum_accumulator #(.ACC_W(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .flush(flush), .clear(clear),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_total(b_out_total),
        .out_count(b_out_count), .out_overflow(b_out_overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: a frame is just the list of accepted beat values.
    int q[$];
    bit m_done;
    int m_tot_a, m_tot_b, m_cnt;
    bit m_ovf_a, m_ovf_b;

    typedef struct {
        bit       v;
        bit [4:0] val;
        bit       fl;
        bit       clr;
        bit       rdy;
        bit       e_valid;
        int       e_total;
        int       e_count;
        int       e_total_b;
        bit       e_ovf_b;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_done = 0; m_cnt = 0;
        m_tot_a = 0; m_tot_b = 0; m_ovf_a = 0; m_ovf_b = 0;
    endtask

    task automatic model_step();
        int s;
        if (clear) begin
            model_reset();
        end else if (m_done) begin
            if (out_ready) begin
                m_done = 0;
                q.delete();
            end
        end else begin
            if (in_valid) q.push_back(int'({in_cout, in_sum}));
            if ((in_valid && q.size() == FL) || (flush && q.size() > 0)) begin
                s = 0;
                foreach (q[i]) s += q[i];
                m_tot_a = (s > MAX_A) ? MAX_A : s;
                m_tot_b = (s > MAX_B) ? MAX_B : s;
                m_ovf_a = (s > MAX_A);
                m_ovf_b = (s > MAX_B);
                m_cnt   = q.size();
                m_done  = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " a_in_ready"},   a_in_ready,     !m_done);
        chk({tag, " a_out_valid"},  a_out_valid,    m_done);
        chk({tag, " a_out_total"},  a_out_total,    m_tot_a);
        chk({tag, " a_out_count"},  a_out_count,    m_cnt);
        chk({tag, " a_overflow"},   a_out_overflow, m_ovf_a);
        chk({tag, " b_in_ready"},   b_in_ready,     !m_done);
        chk({tag, " b_out_valid"},  b_out_valid,    m_done);
        chk({tag, " b_out_total"},  b_out_total,    m_tot_b);
        chk({tag, " b_out_count"},  b_out_count,    m_cnt);
        chk({tag, " b_overflow"},   b_out_overflow, m_ovf_b);
    endtask

    task automatic step(input bit v, input bit [4:0] val, input bit fl,
                        input bit clr, input bit rdy, input string tag);
        @(negedge clk);
        in_valid  = v;
        in_cout   = val[4];
        in_sum    = val[3:0];
        flush     = fl;
        clear     = clr;
        out_ready = rdy;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic add(input int n, input bit v, input bit [4:0] val, input bit fl,
                       input bit clr, input bit rdy, input bit ev, input int et,
                       input int ec, input int etb, input bit eob);
        vec_t e;
        e = '{v, val, fl, clr, rdy, ev, et, ec, etb, eob};
        for (int i = 0; i < n; i++) tbl.push_back(e);
    endtask

    initial begin
        bit [4:0] rv;

        add(7, 1, 5'd30, 0, 0, 0, 0,   0, 0,  0, 0);
        add(1, 1, 5'd30, 0, 0, 0, 1, 240, 8, 63, 1);
        add(5, 1, 5'd30, 0, 0, 0, 1, 240, 8, 63, 1);
        add(1, 1, 5'd30, 0, 0, 1, 0, 240, 8, 63, 1);
        add(3, 1, 5'd5,  0, 0, 0, 0, 240, 8, 63, 1);
        add(1, 0, 5'd0,  1, 0, 0, 1,  15, 3, 15, 0);
        add(1, 0, 5'd0,  0, 0, 1, 0,  15, 3, 15, 0);
        add(1, 0, 5'd0,  1, 0, 0, 0,  15, 3, 15, 0);
        add(7, 1, 5'd1,  0, 0, 0, 0,  15, 3, 15, 0);
        add(1, 1, 5'd1,  0, 0, 0, 1,   8, 8,  8, 0);
        add(1, 0, 5'd0,  0, 0, 1, 0,   8, 8,  8, 0);
        add(4, 1, 5'd7,  0, 0, 0, 0,   8, 8,  8, 0);
        add(1, 1, 5'd7,  0, 1, 0, 0,   0, 0,  0, 0);
        add(7, 1, 5'd1,  0, 0, 0, 0,   0, 0,  0, 0);
        add(1, 1, 5'd1,  0, 0, 1, 1,   8, 8,  8, 0);
        add(1, 0, 5'd0,  0, 0, 1, 0,   8, 8,  8, 0);

        rst_n = 1'b0;
        in_valid = 0; in_sum = 0; in_cout = 0; flush = 0; clear = 0; out_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            step(tbl[k].v, tbl[k].val, tbl[k].fl, tbl[k].clr, tbl[k].rdy, "table");
            chk($sformatf("vec%0d out_valid", k), a_out_valid, tbl[k].e_valid);
            chk($sformatf("vec%0d out_total", k), a_out_total, tbl[k].e_total);
            chk($sformatf("vec%0d out_count", k), a_out_count, tbl[k].e_count);
            chk($sformatf("vec%0d b_total", k),   b_out_total, tbl[k].e_total_b);
            chk($sformatf("vec%0d b_ovf", k),     b_out_overflow, tbl[k].e_ovf_b);
        end

        // Asynchronous reset while a result is pending.
        for (int i = 0; i < FL; i++) step(1, 5'd2, 0, 0, 0, "pre_rst");
        chk("pre_rst valid", a_out_valid, 1'b1);
        @(negedge clk);
        in_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async out_valid", a_out_valid, 1'b0);
        chk("async out_total", a_out_total, 12'd0);
        chk("async in_ready",  a_in_ready,  1'b1);
        chk("async b_valid",   b_out_valid, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 5'd0, 0, 0, 0, "post_rst");

        // FRAME_LEN boundary with flush on the final beat: still one frame.
        for (int i = 0; i < FL - 1; i++) step(1, 5'd3, 0, 0, 0, "fl_last");
        step(1, 5'd3, 1, 0, 0, "fl_last");
        chk("fl_last total", a_out_total, 12'd24);
        step(0, 5'd0, 0, 0, 1, "fl_last");

        for (int i = 0; i < 800; i++) begin
            rv = ($urandom % 2) ? 5'd30 : 5'($urandom_range(0, 30));
            step(($urandom % 4) != 0, rv, ($urandom % 8) == 0,
                 ($urandom % 50) == 0, $urandom % 2, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_sum_accumulator.md
Name: adder_sum_accumulator

Overview:
Downstream stage of the 4-bit ripple-carry adder. It consumes each adder result {cout, s[3:0]}, a value from 0 to 30, through a valid/ready handshake and accumulates FRAME_LEN results into a saturating ACC_W-bit total. It then presents the frame total, beat count and overflow flag on a valid/ready output. It is the first clocked stage after the combinational adder datapath.

Parameters:
ACC_W, 12, accumulator/total width in bits; must be >= 5.
FRAME_LEN, 8, beats per frame; must be >= 1.
CNT_W, $clog2(FRAME_LEN+1), beat-counter width (derived).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  adder result valid
in_ready  out  1  block can accept a result
in_sum  in  4  adder sum s[3:0]
in_cout  in  1  adder carry-out
flush  in  1  close the current partial frame early
clear  in  1  synchronous abort; discard the frame
out_valid  out  1  frame result available
out_ready  in  1  consumer takes the result
out_total  out  ACC_W  saturated frame sum
out_count  out  CNT_W  beats in the frame
out_overflow  out  1  saturation occurred in the frame

Behaviour:
- Single clock domain; reset is asynchronous and active-low. rst_n low forces state ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, out_total=0, out_count=0, out_overflow=0. in_ready=1 after reset.
- Beat value = zero-extended {in_cout, in_sum} (5 bits). A beat is accepted when in_valid & in_ready.
- Two states:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1; out_total, out_count and out_overflow are held stable.
- ACCUM, beat accepted: acc <= min(acc + value, 2^ACC_W-1); ovf <= ovf | (acc + value > 2^ACC_W-1); cnt <= cnt+1. The addition is computed at ACC_W+1 bits.
- ACCUM -> DONE when either:
  - a beat is accepted with cnt == FRAME_LEN-1, or
  - flush=1 and the post-update count is > 0.
  On the transition: out_total, out_count and out_overflow load the post-update acc, cnt and ovf. out_valid rises on the clock edge after the final beat is accepted (latency 1 cycle).
- Flush and a beat in the same cycle: the beat is included, then the frame closes.
- Flush with count 0 and no beat: ignored.
- DONE -> ACCUM on out_valid & out_ready. acc, cnt and ovf clear on that edge. in_ready is 1 in the next cycle, so there is a minimum one-cycle bubble per frame.
- clear=1 (highest priority, any state):
  - next state ACCUM; acc, cnt, ovf and out_valid go to 0;
  - a beat presented in the same cycle is dropped;
  - a pending DONE result is discarded even if out_ready=1;
  - out_total, out_count and out_overflow reset to 0.
- Saturation is sticky for the frame: out_total stays at 2^ACC_W-1 once reached.
- FRAME_LEN=1: every accepted beat produces a frame.
- Asserting rst_n low mid-frame or in DONE takes effect immediately and asynchronously; the frame is lost.

Decomposition:
- Shared package adder_pkg:
  - typedef acc_state_t {ACCUM, DONE};
  - localparam ADD_RES_W = 5 (adder result width);
  - localparam ADD_RES_MAX = 30.
- One natural sub-module: sat_accum_reg, an ACC_W-bit saturating accumulate register with clear, add-enable and sticky overflow. The top level holds the FSM, beat counter and output registers.

Test Plan:
- Defaults, 8 back-to-back beats of cout=1, sum=4'hE (30) -> out_valid one cycle after the 8th accept; out_total=240, out_count=8, out_overflow=0.
- out_ready held low 5 cycles in DONE with in_valid=1 -> in_ready=0, outputs stable; after the handshake, in_ready=1 the next cycle and a new frame starts from 0.
- 3 beats of 5, then flush alone -> out_total=15, out_count=3. A flush with count 0 produces no out_valid.
- ACC_W=6, 8 beats of 30 -> out_total=63, out_overflow=1. The next frame of 8 beats of 1 -> out_total=8, out_overflow=0.
- 4 beats of 7, then clear coincident with a beat, then 8 beats of 1 -> first frame discarded, the coincident beat dropped, out_total=8.
- rst_n pulsed low asynchronously while out_valid=1 -> out_valid and out_total drop to 0 before the next clock edge; in_ready=1 after release.
